// File: rtl/board_ctl_if.sv
// board_ctl_if: board-side pins of board_ctl (btn_n/led_in in, btn/btn_press/core_reset/led out)
interface board_ctl_if #(
   parameter int NBTN = 1,
   parameter int NLED = 8
);
   logic [NBTN-1:0] btn_n;
   logic [NBTN-1:0] btn;
   logic [NBTN-1:0] btn_press;
   logic            core_reset;
   logic [NLED-1:0] led_in;
   logic [NLED-1:0] led;
   modport master (output btn_n, led_in, input btn, btn_press, core_reset, led);
   modport slave (input btn_n, led_in, output btn, btn_press, core_reset, led);
endinterface

// File: rtl/board_ctl.sv
// board_ctl: button debounce, stretched core reset and heartbeat LEDs; ports clk, reset (async), io (btn_n/led_in in; btn/btn_press/core_reset/led out)
module board_ctl #(
   parameter int BOARD_CK     = 32000000,
   parameter int NBTN         = 1,
   parameter int RST_BTN      = 0,
   parameter int DEBOUNCE_CYC = BOARD_CK / 100,
   parameter int RST_HOLD_CYC = 16,
   parameter int HB_HALF      = BOARD_CK / 2,
   parameter int NLED         = 8
) (
   input logic        clk,
   input logic        reset,
   board_ctl_if.slave io
);
   localparam int DW = $clog2(DEBOUNCE_CYC);
   localparam int RW = $clog2(RST_HOLD_CYC + 1);
   localparam int HW = HB_HALF > 1 ? $clog2(HB_HALF) : 1;
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
   localparam logic [RW-1:0] HOLD_LAST = RW'(RST_HOLD_CYC - 1);
   localparam logic [HW-1:0] HB_LAST = HW'(HB_HALF - 1);
   typedef enum logic {HOLD, RUN} state_t;
   state_t                  state_q, state_d;
   logic [NBTN-1:0]         sync1_q, sync2_q, s;
   logic [NBTN-1:0]         btn_q, btn_d, press_q, press_d;
   logic [NBTN-1:0][DW-1:0] db_cnt_q, db_cnt_d;
   logic [RW-1:0]           hold_cnt_q, hold_cnt_d;
   logic                    core_reset_q, core_reset_d;
   logic [HW-1:0]           hb_cnt_q, hb_cnt_d;
   logic                    hb_q, hb_d;
   logic [NLED-1:0]         led_q, led_d;
   assign s = ~sync2_q;
   // any sample agreeing with btn restarts the count, so only a run of DEBOUNCE_CYC disagreeing samples flips btn
   always_comb begin
      btn_d = btn_q;
      db_cnt_d = db_cnt_q;
      for (int i = 0; i < NBTN; i++) begin
         db_cnt_d[i] = (s[i] == btn_q[i] || db_cnt_q[i] == DB_LAST) ? '0 : db_cnt_q[i] + DW'(1);
         btn_d[i] = (s[i] != btn_q[i] && db_cnt_q[i] == DB_LAST) ? s[i] : btn_q[i];
      end
      press_d = btn_d & ~btn_q;
   end
   // a held reset button pins the FSM in HOLD with the stretch counter cleared
   always_comb begin
      state_d = state_q;
      hold_cnt_d = hold_cnt_q;
      core_reset_d = core_reset_q;
      if (btn_q[RST_BTN]) begin
         state_d = HOLD;
         hold_cnt_d = '0;
         core_reset_d = 1'b1;
      end else if (state_q == HOLD) begin
         hold_cnt_d = hold_cnt_q == HOLD_LAST ? '0 : hold_cnt_q + RW'(1);
         state_d = hold_cnt_q == HOLD_LAST ? RUN : HOLD;
         core_reset_d = hold_cnt_q != HOLD_LAST;
      end
   end
   always_comb begin
      hb_cnt_d = hb_cnt_q == HB_LAST ? '0 : hb_cnt_q + HW'(1);
      hb_d = hb_q ^ (hb_cnt_q == HB_LAST);
      led_d = core_reset_q ? {NLED{hb_q}} : io.led_in;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
         btn_q <= '0;
         press_q <= '0;
         db_cnt_q <= '0;
         state_q <= HOLD;
         hold_cnt_q <= '0;
         core_reset_q <= 1'b1;
         hb_cnt_q <= '0;
         hb_q <= 1'b0;
         led_q <= '0;
      end else begin
         sync1_q <= io.btn_n;
         sync2_q <= sync1_q;
         btn_q <= btn_d;
         press_q <= press_d;
         db_cnt_q <= db_cnt_d;
         state_q <= state_d;
         hold_cnt_q <= hold_cnt_d;
         core_reset_q <= core_reset_d;
         hb_cnt_q <= hb_cnt_d;
         hb_q <= hb_d;
         led_q <= led_d;
      end
   end
   assign io.btn = btn_q;
   assign io.btn_press = press_q;
   assign io.core_reset = core_reset_q;
   assign io.led = led_q;
endmodule

// File: tb/tb_board_ctl.sv
// tb_board_ctl: directed stimulus with a history-based reference model checked every cycle
module tb_board_ctl;
   localparam int NBTN = 2;
   localparam int D = 4;
   localparam int H = 8;
   localparam int HB = 5;
   localparam int NLED = 4;
   logic clk, reset;
   int total = 0, bad = 0;
   board_ctl_if #(.NBTN(NBTN), .NLED(NLED)) io ();
   board_ctl #(
      .BOARD_CK(1000), .NBTN(NBTN), .RST_BTN(0), .DEBOUNCE_CYC(D),
      .RST_HOLD_CYC(H), .HB_HALF(HB), .NLED(NLED)
   ) dut (.clk(clk), .reset(reset), .io(io));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(string n, logic [7:0] got, logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
      end
   endtask
   // model: btn flips after D consecutive synchronised samples differing from it;
   // core_reset is low once btn[0] has read 0 for H consecutive edges; hb is edge count / HB parity
   logic [NBTN-1:0] raw_h[$];
   logic [NBTN-1:0] s_h[$];
   logic [NBTN-1:0] m_btn, m_press, nb, s_now;
   logic            m_core, m_hb, all_diff;
   logic [NLED-1:0] m_led;
   int              quiet, e;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         raw_h.delete();
         s_h.delete();
         m_btn = '0;
         m_press = '0;
         m_core = 1'b1;
         m_hb = 1'b0;
         m_led = '0;
         quiet = 0;
         e = 0;
      end else begin
         raw_h.push_back(io.btn_n);
         if (raw_h.size() > 3) void'(raw_h.pop_front());
         s_now = raw_h.size() == 3 ? ~raw_h[0] : '0;
         s_h.push_back(s_now);
         if (s_h.size() > D) void'(s_h.pop_front());
         nb = m_btn;
         for (int i = 0; i < NBTN; i++) begin
            all_diff = s_h.size() == D;
            for (int k = 0; k < s_h.size(); k++)
               if (s_h[k][i] == m_btn[i]) all_diff = 1'b0;
            if (all_diff) nb[i] = ~m_btn[i];
         end
         quiet = m_btn[0] ? 0 : quiet + 1;
         m_led = m_core ? {NLED{m_hb}} : io.led_in;
         e++;
         m_hb = ((e / HB) % 2) == 1;
         m_press = nb & ~m_btn;
         m_btn = nb;
         m_core = quiet < H;
      end
   end
   always @(negedge clk) begin
      chk("btn", 8'(io.btn), 8'(m_btn));
      chk("btn_press", 8'(io.btn_press), 8'(m_press));
      chk("core_reset", 8'(io.core_reset), 8'(m_core));
      chk("led", 8'(io.led), 8'(m_led));
   end
   task automatic step(int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic pwr_up();
      step(5);
      chk("pu_led_e5", 8'(io.led), 8'h0);
      step(1);
      chk("pu_led_e6", 8'(io.led), 8'hf);
      step(1);
      chk("pu_core_e7", 8'(io.core_reset), 8'd1);
      step(1);
      chk("pu_core_e8", 8'(io.core_reset), 8'd0);
      chk("pu_btn", 8'(io.btn), 8'h0);
      step(1);
      chk("pu_led_e9", 8'(io.led), 8'ha);
   endtask
   task automatic async_chk(string n);
      #2 reset = 1'b1;
      #1;
      chk({n, "_core"}, 8'(io.core_reset), 8'd1);
      chk({n, "_btn"}, 8'(io.btn), 8'h0);
      chk({n, "_led"}, 8'(io.led), 8'h0);
      chk({n, "_press"}, 8'(io.btn_press), 8'h0);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end
   initial begin
      reset = 1'b0;
      io.btn_n = 2'b11;
      io.led_in = 4'b1010;
      #1 reset = 1'b1;
      #1;
      chk("rst_core", 8'(io.core_reset), 8'd1);
      chk("rst_btn", 8'(io.btn), 8'h0);
      chk("rst_led", 8'(io.led), 8'h0);
      step(2);
      reset = 1'b0;
      pwr_up();
      io.btn_n[1] = 1'b0;
      step(5);
      chk("b1_not_yet", 8'(io.btn), 8'h0);
      step(1);
      chk("b1_rise", 8'(io.btn), 8'h2);
      chk("b1_press", 8'(io.btn_press), 8'h2);
      step(1);
      chk("b1_press_1cyc", 8'(io.btn_press), 8'h0);
      chk("b1_core", 8'(io.core_reset), 8'd0);
      step(3);
      io.btn_n[1] = 1'b1;
      step(5);
      chk("b1_still", 8'(io.btn), 8'h2);
      step(1);
      chk("b1_fall", 8'(io.btn), 8'h0);
      chk("b1_no_rel_pulse", 8'(io.btn_press), 8'h0);
      repeat (5) begin
         io.btn_n[1] = 1'b0;
         step(3);
         io.btn_n[1] = 1'b1;
         step(1);
         chk("glitch", 8'(io.btn), 8'h0);
      end
      step(4);
      io.btn_n[0] = 1'b0;
      step(6);
      chk("b0_rise", 8'(io.btn), 8'h1);
      chk("b0_core_lag", 8'(io.core_reset), 8'd0);
      step(1);
      chk("b0_core_rise", 8'(io.core_reset), 8'd1);
      step(13);
      io.btn_n[0] = 1'b1;
      step(6);
      chk("b0_fall", 8'(io.btn), 8'h0);
      step(7);
      chk("stretch_e7", 8'(io.core_reset), 8'd1);
      step(1);
      chk("stretch_e8", 8'(io.core_reset), 8'd0);
      step(1);
      chk("led_follow", 8'(io.led), 8'ha);
      io.btn_n[0] = 1'b0;
      step(20);
      io.btn_n[0] = 1'b1;
      step(4);
      io.btn_n[0] = 1'b0;
      step(6);
      chk("repress_btn", 8'(io.btn), 8'h1);
      chk("repress_core", 8'(io.core_reset), 8'd1);
      step(10);
      io.btn_n[0] = 1'b1;
      step(13);
      chk("restart_e13", 8'(io.core_reset), 8'd1);
      step(1);
      chk("restart_e14", 8'(io.core_reset), 8'd0);
      step(2);
      io.btn_n[1] = 1'b0;
      step(8);
      io.btn_n[1] = 1'b1;
      step(3);
      async_chk("mid_db");
      step(1);
      reset = 1'b0;
      pwr_up();
      io.btn_n[0] = 1'b0;
      step(10);
      io.btn_n[0] = 1'b1;
      step(9);
      async_chk("mid_st");
      step(1);
      reset = 1'b0;
      pwr_up();
      step(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
